rcu_rst_seq: RTL

Reset/clock-switch sequencer directly downstream of `rcu_core`. It consumes the raw PLL lock indication and drives the clock-select for the glitchless system clock mux. It releases the per-domain synchronous resets in a fixed order once the PLL has been stably locked for a programmable time. It also recovers from lock loss and from software reset requests.

---
 rtl/rcu_rst_seq_pkg.sv | 22 ++
 rtl/rcu_sync2.sv | 23 ++
 rtl/rcu_rst_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/rcu_rst_seq_pkg.sv
// rcu_rst_seq_pkg: state encodings and default sizing shared by the reset sequencer
`ifndef RCU_STATE_WIDTH
`define RCU_STATE_WIDTH 3
`endif

package rcu_rst_seq_pkg;

    localparam int N_RST_DEF          = 3;
    localparam int LOCK_CNT_WIDTH_DEF = 16;
    localparam int SW_DLY_DEF         = 8;
    localparam int STAGE_DLY_DEF      = 4;

    typedef enum logic [`RCU_STATE_WIDTH-1:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        SWITCH    = 3'd3,
        RELEASE   = 3'd4,
        RUN       = 3'd5
    } state_t;

endpackage

// File: rtl/rcu_sync2.sv
// rcu_sync2: two-flop synchronizer with asynchronous active-low reset to 0
module rcu_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rcu_rst_seq.sv
// rcu_rst_seq: lock-qualified clock switch and ordered per-domain reset release
module rcu_rst_seq
    import rcu_rst_seq_pkg::*;
#(
    parameter int N_RST          = N_RST_DEF,
    parameter int LOCK_CNT_WIDTH = LOCK_CNT_WIDTH_DEF,
    parameter int SW_DLY         = SW_DLY_DEF,
    parameter int STAGE_DLY      = STAGE_DLY_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         pll_lock_i,
    input  logic [LOCK_CNT_WIDTH-1:0]    lock_cnt_i,
    input  logic                         sw_rst_req_i,
    input  logic                         clr_err_i,
    output logic                         clk_sel_o,
    output logic [N_RST-1:0]             rst_n_o,
    output logic [`RCU_STATE_WIDTH-1:0]  state_o,
    output logic                         lock_err_o
);

    localparam int DMAX = (SW_DLY > N_RST*STAGE_DLY) ? SW_DLY : N_RST*STAGE_DLY;
    localparam int DW   = $clog2(DMAX + 1);
    localparam logic [DW-1:0] SW_LAST  = DW'(SW_DLY - 1);
    // Release counter runs one ahead so a software restart can hold all domains for a cycle at 0
    localparam logic [DW-1:0] REL_LAST = DW'(1 + (N_RST-1)*STAGE_DLY);

    state_t                    state_q, state_d;
    logic [LOCK_CNT_WIDTH-1:0] lcnt_q, lcnt_d, lock_max;
    logic [DW-1:0]             dcnt_q, dcnt_d;
    logic [N_RST-1:0]          rst_n_d;
    logic                      lock_s, clk_sel_d, err_d, up_d;

    rcu_sync2 #(.W(1)) u_lock_sync (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .d     (pll_lock_i),
        .q     (lock_s)
    );

    assign lock_max = (lock_cnt_i == '0) ? '0 : lock_cnt_i - 1'b1;
    assign state_o  = state_q;

    always_comb begin
        state_d   = state_q;
        lcnt_d    = lcnt_q;
        dcnt_d    = dcnt_q;
        clk_sel_d = clk_sel_o;
        err_d     = clr_err_i ? 1'b0 : lock_err_o;
        case (state_q)
            IDLE:      state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    lcnt_d  = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    lcnt_d  = '0;
                end else if (lcnt_q >= lock_max) begin
                    state_d   = SWITCH;
                    clk_sel_d = 1'b1;
                    dcnt_d    = '0;
                end else begin
                    lcnt_d = (&lcnt_q) ? lcnt_q : lcnt_q + 1'b1;
                end
            end
            SWITCH: begin
                if (dcnt_q == SW_LAST) begin
                    state_d = RELEASE;
                    dcnt_d  = DW'(1);
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (dcnt_q == REL_LAST) state_d = RUN;
                else dcnt_d = dcnt_q + 1'b1;
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (state_q inside {SWITCH, RELEASE, RUN}) begin
            if (!lock_s) begin
                state_d   = WAIT_LOCK;
                clk_sel_d = 1'b0;
                err_d     = 1'b1;
            end else if (sw_rst_req_i && state_q != SWITCH) begin
                state_d = RELEASE;
                dcnt_d  = '0;
            end
        end
        up_d = state_d inside {RELEASE, RUN};
        for (int k = 0; k < N_RST; k++)
            rst_n_d[k] = up_d && (dcnt_d >= DW'(1 + k*STAGE_DLY));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            lcnt_q     <= '0;
            dcnt_q     <= '0;
            clk_sel_o  <= 1'b0;
            rst_n_o    <= '0;
            lock_err_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            lcnt_q     <= lcnt_d;
            dcnt_q     <= dcnt_d;
            clk_sel_o  <= clk_sel_d;
            rst_n_o    <= rst_n_d;
            lock_err_o <= err_d;
        end
    end

endmodule
